// File: rtl/tube_scan_decoder.sv
// Receive side of a scanned 4-digit 7-segment bus: sync, deglitch, decode and assemble one frame per scan.
// Optional all-segments-off (blank) digit support is enabled by defining TUBE_DEC_BLANK_EN.
module tube_scan_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT_BITS  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] sel_in,
  input  logic [7:0] dig_in,
  input  logic       err_clr,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] dp_out,
  output logic       frame_vld,
  output logic       stale,
  output logic       err,
  output logic [1:0] err_digit
`ifdef TUBE_DEC_BLANK_EN
  ,
  output logic [3:0] blank_out
`endif
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_HIT = CW'(STABLE_CYCLES - 2);

  logic [5:0]              sel_s1_q, sel_s2_q;
  logic [7:0]              dig_s1_q, dig_s2_q;
  logic [13:0]             prev_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [3:0][3:0]         stg_q, stg_d, dout_q, dout_d;
  logic [3:0]              sdp_q, sdp_d, dp_q, dp_d;
  logic [3:0]              mask_q, mask_d;
  logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
  logic                    vld_q, vld_d;
  logic                    stale_q, stale_d;
  logic                    err_q, err_d;
  logic [1:0]              errd_q, errd_d;
`ifdef TUBE_DEC_BLANK_EN
  logic [3:0]              sbl_q, sbl_d, bl_q, bl_d;
  logic                    blank;
`endif

  logic        act, same, cap, seg_ok;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic [6:0]  seg;

  assign seg  = ~dig_s2_q[6:0];
  assign same = ({sel_s2_q, dig_s2_q} == prev_q);
  assign cap  = act && same && (cnt_q == CNT_HIT);

  always_comb begin
    act = 1'b1;
    idx = 2'd0;
    case (sel_s2_q)
      6'b111110: idx = 2'd0;
      6'b111101: idx = 2'd1;
      6'b111011: idx = 2'd2;
      6'b110111: idx = 2'd3;
      default:   act = 1'b0;
    endcase
  end

  always_comb begin
    seg_ok = 1'b1;
    nib    = 4'h0;
`ifdef TUBE_DEC_BLANK_EN
    blank  = 1'b0;
`endif
    case (seg)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
`ifdef TUBE_DEC_BLANK_EN
      7'h00: blank = 1'b1;
`endif
      default: seg_ok = 1'b0;
    endcase
  end

  // Counter saturates so a long dwell captures exactly once.
  always_comb begin
    if (!act || !same)        cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    stg_d   = stg_q;
    sdp_d   = sdp_q;
    dout_d  = dout_q;
    dp_d    = dp_q;
    mask_d  = mask_q;
    tmo_d   = tmo_q + 1'b1;
    vld_d   = 1'b0;
    stale_d = stale_q;
    err_d   = err_q;
    errd_d  = errd_q;
`ifdef TUBE_DEC_BLANK_EN
    sbl_d   = sbl_q;
    bl_d    = bl_q;
`endif
    // Frame publishes the old staging; a same-cycle capture lands in the next frame.
    if (mask_q == 4'hF) begin
      dout_d  = stg_q;
      dp_d    = sdp_q;
`ifdef TUBE_DEC_BLANK_EN
      bl_d    = sbl_q;
`endif
      vld_d   = 1'b1;
      mask_d  = 4'h0;
      stale_d = 1'b0;
    end
    if (cap && seg_ok) begin
      stg_d[idx]  = nib;
      sdp_d[idx]  = dig_s2_q[7];
`ifdef TUBE_DEC_BLANK_EN
      sbl_d[idx]  = blank;
`endif
      mask_d[idx] = 1'b1;
      tmo_d       = '0;
    end else if (&tmo_q) begin
      stale_d = 1'b1;
      mask_d  = 4'h0;
    end
    if (cap && !seg_ok) begin
      err_d  = 1'b1;
      errd_d = idx;
    end else if (err_clr) begin
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_s1_q <= '0;
      sel_s2_q <= '0;
      dig_s1_q <= '0;
      dig_s2_q <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      stg_q    <= '0;
      sdp_q    <= '0;
      dout_q   <= '0;
      dp_q     <= '0;
      mask_q   <= '0;
      tmo_q    <= '0;
      vld_q    <= 1'b0;
      stale_q  <= 1'b1;
      err_q    <= 1'b0;
      errd_q   <= '0;
`ifdef TUBE_DEC_BLANK_EN
      sbl_q    <= '0;
      bl_q     <= '0;
`endif
    end else begin
      sel_s1_q <= sel_in;
      sel_s2_q <= sel_s1_q;
      dig_s1_q <= dig_in;
      dig_s2_q <= dig_s1_q;
      prev_q   <= {sel_s2_q, dig_s2_q};
      cnt_q    <= cnt_d;
      stg_q    <= stg_d;
      sdp_q    <= sdp_d;
      dout_q   <= dout_d;
      dp_q     <= dp_d;
      mask_q   <= mask_d;
      tmo_q    <= tmo_d;
      vld_q    <= vld_d;
      stale_q  <= stale_d;
      err_q    <= err_d;
      errd_q   <= errd_d;
`ifdef TUBE_DEC_BLANK_EN
      sbl_q    <= sbl_d;
      bl_q     <= bl_d;
`endif
    end
  end

  assign d0        = dout_q[0];
  assign d1        = dout_q[1];
  assign d2        = dout_q[2];
  assign d3        = dout_q[3];
  assign dp_out    = dp_q;
  assign frame_vld = vld_q;
  assign stale     = stale_q;
  assign err       = err_q;
  assign err_digit = errd_q;
`ifdef TUBE_DEC_BLANK_EN
  assign blank_out = bl_q;
`endif

endmodule

// File: tb/tb_tube_scan_decoder.sv
// Bench for tube_scan_decoder: directed scans checked every cycle against a history-based model.
module tb_tube_scan_decoder;
  localparam int S  = 4;
  localparam int T  = 8;
  localparam int HL = S + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] sel_in;
  logic [7:0] dig_in;
  logic       err_clr;
  logic [3:0] d0, d1, d2, d3, dp_out;
  logic       frame_vld, stale, err;
  logic [1:0] err_digit;
`ifdef TUBE_DEC_BLANK_EN
  logic [3:0] blank_out;
`endif

  tube_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_BITS(T)) dut (
    .clk(clk), .rst_n(rst_n), .sel_in(sel_in), .dig_in(dig_in), .err_clr(err_clr),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .dp_out(dp_out), .frame_vld(frame_vld),
    .stale(stale), .err(err), .err_digit(err_digit)
`ifdef TUBE_DEC_BLANK_EN
    , .blank_out(blank_out)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int frames = 0;
  bit started = 0;

  // Model state
  logic [13:0]     hist [HL];
  logic [3:0][3:0] m_d, m_stg;
  logic [3:0]      m_dp, m_sdp, m_bl, m_sbl, m_mask;
  logic            m_vld, m_stale, m_err;
  logic [1:0]      m_errd;
  int              tmo;

  logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int sel_idx(input logic [5:0] s);
    case (s)
      6'b111110: return 0;
      6'b111101: return 1;
      6'b111011: return 2;
      6'b110111: return 3;
      default:   return -1;
    endcase
  endfunction

  // Returns 0..15 for a digit, 16 for an accepted blank, -1 for illegal.
  function automatic int seg_nib(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (segtab[i] == p) return i;
`ifdef TUBE_DEC_BLANK_EN
    if (p == 7'h00) return 16;
`endif
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [13:0] v;
    bit cap;
    int ix, nb;
    if (!rst_n) begin
      for (int i = 0; i < HL; i++) hist[i] = '0;
      m_d = '0; m_stg = '0; m_dp = '0; m_sdp = '0; m_bl = '0; m_sbl = '0; m_mask = '0;
      m_vld = 0; m_stale = 1; m_err = 0; m_errd = 0; tmo = 0;
    end else begin
      for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {sel_in, dig_in};
      // The decoder sees inputs two cycles late; a capture needs S identical active samples.
      v   = hist[2];
      cap = (sel_idx(v[13:8]) >= 0) && (hist[S+2] != v);
      for (int j = 3; j <= S + 1; j++) if (hist[j] != v) cap = 0;
      ix = sel_idx(v[13:8]);
      nb = cap ? seg_nib(~v[6:0]) : -1;
      m_vld = 0;
      if (m_mask == 4'hF) begin
        m_d = m_stg; m_dp = m_sdp; m_bl = m_sbl;
        m_vld = 1; m_mask = 0; m_stale = 0;
        frames++;
      end
      if (cap && nb >= 0) begin
        m_stg[ix]  = (nb == 16) ? 4'h0 : nb[3:0];
        m_sbl[ix]  = (nb == 16);
        m_sdp[ix]  = v[7];
        m_mask[ix] = 1'b1;
        tmo = 0;
      end else begin
        tmo++;
        if (tmo == (1 << T)) begin
          tmo = 0; m_stale = 1; m_mask = 0;
        end
      end
      if (cap && nb < 0) begin
        m_err = 1; m_errd = ix[1:0];
      end else if (err_clr) begin
        m_err = 0;
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    logic [31:0] act, exp;
    if (started) begin
      act = {3'b0, d0, d1, d2, d3, dp_out, frame_vld, stale, err, err_digit, 4'h0};
      exp = {3'b0, m_d[0], m_d[1], m_d[2], m_d[3], m_dp, m_vld, m_stale, m_err, m_errd, 4'h0};
`ifdef TUBE_DEC_BLANK_EN
      act[3:0] = blank_out;
      exp[3:0] = m_bl;
`endif
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, act, exp);
      end
    end
  end

  task automatic lit(input string name, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, a, e);
    end
  endtask

  task automatic dwell(input logic [5:0] s, input logic [7:0] d, input int n);
    sel_in = s;
    dig_in = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] e);
    dwell(6'h3E, a, 20);
    dwell(6'h3D, b, 20);
    dwell(6'h3B, c, 20);
    dwell(6'h37, e, 20);
    dwell(6'h3F, 8'hFF, 4);
  endtask

  task automatic chk_reset(input string tag);
    lit({tag, "_d0"}, d0, 0);
    lit({tag, "_d3"}, d3, 0);
    lit({tag, "_dp"}, dp_out, 0);
    lit({tag, "_vld"}, frame_vld, 0);
    lit({tag, "_stale"}, stale, 1);
    lit({tag, "_err"}, err, 0);
  endtask

  initial begin
    int f0;
    rst_n = 0; sel_in = 6'h3F; dig_in = 8'hFF; err_clr = 0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1;

    // 1: plain scan 1,2,3,4
    f0 = frames;
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99);
    lit("t1_frames", frames - f0, 1);
    lit("t1_d0", d0, 1); lit("t1_d1", d1, 2); lit("t1_d2", d2, 3); lit("t1_d3", d3, 4);
    lit("t1_dp", dp_out, 4'hF);
    lit("t1_stale", stale, 0);

    // 2: digit 2 shows "8" with dp bit low
    f0 = frames;
    scan(8'hF9, 8'hA4, 8'h00, 8'h99);
    lit("t2_frames", frames - f0, 1);
    lit("t2_d2", d2, 8);
    lit("t2_dp", dp_out, 4'b1011);

    // 3: single-cycle glitch on digit 1
    f0 = frames;
    dwell(6'h3E, 8'hF9, 20);
    dwell(6'h3D, 8'hA4, 3);
    dwell(6'h3D, 8'h00, 1);
    dwell(6'h3D, 8'hA4, 10);
    dwell(6'h3B, 8'hB0, 20);
    dwell(6'h37, 8'h99, 20);
    dwell(6'h3F, 8'hFF, 4);
    lit("t3_frames", frames - f0, 1);
    lit("t3_d1", d1, 2);
    lit("t3_err", err, 0);

    // 4: all segments off on digit 3
    f0 = frames;
    dwell(6'h3E, 8'hF9, 20);
    dwell(6'h3D, 8'hA4, 20);
    dwell(6'h3B, 8'hB0, 20);
    dwell(6'h37, 8'hFF, 20);
    dwell(6'h3F, 8'hFF, 4);
`ifdef TUBE_DEC_BLANK_EN
    lit("t4_frames", frames - f0, 1);
    lit("t4_d3", d3, 0);
    lit("t4_blank", blank_out, 4'b1000);
`else
    lit("t4_frames", frames - f0, 0);
    lit("t4_err", err, 1);
    lit("t4_err_digit", err_digit, 3);
`endif
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    dwell(6'h3F, 8'hFF, 2);
    lit("t4_err_clr", err, 0);

    // 5: partial scan then long idle
    f0 = frames;
    dwell(6'h3E, 8'hF9, 20);
    dwell(6'h3D, 8'hA4, 20);
    dwell(6'h3B, 8'hB0, 20);
    dwell(6'h3F, 8'hFF, 300);
    lit("t5_frames_idle", frames - f0, 0);
    lit("t5_stale", stale, 1);
    lit("t5_d0_hold", d0, 1);
    lit("t5_d1_hold", d1, 2);
    f0 = frames;
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99);
    lit("t5_frames_rescan", frames - f0, 1);
    lit("t5_stale_clear", stale, 0);

    // 6: reset mid-frame
    dwell(6'h3E, 8'h99, 20);
    dwell(6'h3D, 8'hB0, 20);
    rst_n = 0; sel_in = 6'h3F; dig_in = 8'hFF;
    @(negedge clk);
    chk_reset("t6_reset");
    rst_n = 1;
    f0 = frames;
    scan(8'hA4, 8'hF9, 8'h99, 8'hB0);
    lit("t6_frames", frames - f0, 1);
    lit("t6_d0", d0, 2); lit("t6_d3", d3, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
